// File: rtl/burst_master_port.sv
// Bit-serial bus master port with bursts: serialises slave ID, memory address and
// burst length, then moves 1..2^LEN_WIDTH data beats with ack timeout reporting.
module burst_master_port #(
  parameter int ADDR_WIDTH     = 16,
  parameter int DATA_WIDTH     = 8,
  parameter int SLAVE_ID_WIDTH = 4,
  parameter int LEN_WIDTH      = 4,
  parameter int ACK_TIMEOUT    = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] daddr,
  input  logic                  dmode,
  input  logic [LEN_WIDTH-1:0]  dlen,
  input  logic                  dvalid,
  output logic                  dready,
  input  logic [DATA_WIDTH-1:0] dwdata,
  input  logic                  dwvalid,
  output logic                  dwready,
  output logic [DATA_WIDTH-1:0] drdata,
  output logic                  drvalid,
  output logic                  ddone,
  output logic                  derr,
  output logic                  mwdata,
  output logic                  mmode,
  output logic                  mvalid,
  input  logic                  mrdata,
  input  logic                  svalid,
  output logic                  mbreq,
  input  logic                  mbgrant,
  input  logic                  ack,
  output logic [3:0]            dbg_state
);

  // Handshakes: a command transfers on a cycle with dvalid & dready, a write beat on
  // dwvalid & dwready; drvalid and ddone are single-cycle pulses with no back-pressure.

  localparam int LOW_W   = ADDR_WIDTH - SLAVE_ID_WIDTH;
  localparam int M1      = (SLAVE_ID_WIDTH > LOW_W) ? SLAVE_ID_WIDTH : LOW_W;
  localparam int M2      = (M1 > LEN_WIDTH) ? M1 : LEN_WIDTH;
  localparam int SH_W    = (M2 > DATA_WIDTH) ? M2 : DATA_WIDTH;
  localparam int CNT_MAX = (SH_W > ACK_TIMEOUT) ? SH_W : ACK_TIMEOUT;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam int BW      = LEN_WIDTH + 1;

  typedef enum logic [3:0] {
    IDLE  = 4'd0,
    REQ   = 4'd1,
    SADDR = 4'd2,
    WAIT  = 4'd3,
    ADDR  = 4'd4,
    LEN   = 4'd5,
    WLOAD = 4'd6,
    WDATA = 4'd7,
    RDATA = 4'd8,
    DONE  = 4'd9
  } state_t;

  state_t                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [SH_W-1:0]       sh_q, sh_d;
  logic [DATA_WIDTH-1:0] rbuf_q, rbuf_d;
  logic [BW-1:0]         beat_q, beat_d;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [LEN_WIDTH-1:0]  len_q;
  logic                  derr_d;
  logic [DATA_WIDTH-1:0] drdata_d;
  logic                  drvalid_d;
  logic                  issue;
  logic                  accept;
  logic                  last_beat;

  assign dbg_state = state_q;
  assign last_beat = (beat_q == {1'b0, len_q});

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    sh_d      = sh_q;
    rbuf_d    = rbuf_q;
    beat_d    = beat_q;
    derr_d    = derr;
    drdata_d  = drdata;
    drvalid_d = 1'b0;
    issue     = 1'b0;
    accept    = 1'b0;
    dready    = 1'b0;
    dwready   = 1'b0;
    mbreq     = 1'b0;
    ddone     = 1'b0;

    unique case (state_q)
      IDLE: begin
        dready = 1'b1;
        if (dvalid) begin
          accept  = 1'b1;
          derr_d  = 1'b0;
          state_d = REQ;
        end
      end

      REQ: begin
        mbreq = 1'b1;
        if (mbgrant) begin
          state_d = SADDR;
          cnt_d   = '0;
          sh_d    = SH_W'(addr_q[ADDR_WIDTH-1 -: SLAVE_ID_WIDTH]);
        end
      end

      SADDR: begin
        mbreq = 1'b1;
        issue = 1'b1;
        sh_d  = sh_q >> 1;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(SLAVE_ID_WIDTH - 1)) begin
          state_d = WAIT;
          cnt_d   = '0;
        end
      end

      // Decoder has ACK_TIMEOUT cycles to recognise the slave ID before we give up.
      WAIT: begin
        mbreq = 1'b1;
        if (ack) begin
          state_d = ADDR;
          cnt_d   = '0;
          sh_d    = SH_W'(addr_q[LOW_W-1:0]);
        end else if (cnt_q == CW'(ACK_TIMEOUT - 1)) begin
          derr_d  = 1'b1;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      ADDR: begin
        mbreq = 1'b1;
        issue = 1'b1;
        sh_d  = sh_q >> 1;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(LOW_W - 1)) begin
          state_d = LEN;
          cnt_d   = '0;
          sh_d    = SH_W'(len_q);
        end
      end

      LEN: begin
        mbreq = 1'b1;
        issue = 1'b1;
        sh_d  = sh_q >> 1;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(LEN_WIDTH - 1)) begin
          cnt_d   = '0;
          beat_d  = '0;
          state_d = mmode ? WLOAD : RDATA;
        end
      end

      WLOAD: begin
        mbreq   = 1'b1;
        dwready = 1'b1;
        if (dwvalid) begin
          sh_d    = SH_W'(dwdata);
          cnt_d   = '0;
          state_d = WDATA;
        end
      end

      WDATA: begin
        mbreq = 1'b1;
        issue = 1'b1;
        sh_d  = sh_q >> 1;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(DATA_WIDTH - 1)) begin
          cnt_d   = '0;
          beat_d  = beat_q + BW'(1);
          state_d = last_beat ? DONE : WLOAD;
        end
      end

      // Incoming bits enter at the top and shift down, so LSB-first arrival lands in order.
      RDATA: begin
        mbreq = 1'b1;
        if (svalid) begin
          rbuf_d = {mrdata, rbuf_q[DATA_WIDTH-1:1]};
          cnt_d  = cnt_q + CW'(1);
          if (cnt_q == CW'(DATA_WIDTH - 1)) begin
            drdata_d  = rbuf_d;
            drvalid_d = 1'b1;
            cnt_d     = '0;
            beat_d    = beat_q + BW'(1);
            if (last_beat) state_d = DONE;
          end
        end
      end

      DONE: begin
        ddone   = 1'b1;
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sh_q    <= '0;
      rbuf_q  <= '0;
      beat_q  <= '0;
      addr_q  <= '0;
      len_q   <= '0;
      mmode   <= 1'b0;
      derr    <= 1'b0;
      drdata  <= '0;
      drvalid <= 1'b0;
      mwdata  <= 1'b0;
      mvalid  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sh_q    <= sh_d;
      rbuf_q  <= rbuf_d;
      beat_q  <= beat_d;
      derr    <= derr_d;
      drdata  <= drdata_d;
      drvalid <= drvalid_d;
      // Bus bit is registered: a bit issued in state cycle k is driven in cycle k+1.
      mwdata  <= issue & sh_q[0];
      mvalid  <= issue;
      if (accept) begin
        addr_q <= daddr;
        len_q  <= dlen;
        mmode  <= dmode;
      end
    end
  end

endmodule

// File: tb/tb_burst_master_port.sv
// Directed bench for burst_master_port: a table of commands with hand-computed
// serial headers, plus a mid-burst reset sequence and back-to-back acceptance.
module tb_burst_master_port;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] daddr;
  logic        dmode;
  logic [3:0]  dlen;
  logic        dvalid;
  logic        dready;
  logic [7:0]  dwdata;
  logic        dwvalid;
  logic        dwready;
  logic [7:0]  drdata;
  logic        drvalid;
  logic        ddone;
  logic        derr;
  logic        mwdata;
  logic        mmode;
  logic        mvalid;
  logic        mrdata;
  logic        svalid;
  logic        mbreq;
  logic        mbgrant;
  logic        ack;
  logic [3:0]  dbg_state;

  int checks = 0;
  int errors = 0;
  bit prev_done = 1'b0;

  always #5 clk = ~clk;

  burst_master_port dut (
    .clk(clk), .rst(rst), .daddr(daddr), .dmode(dmode), .dlen(dlen),
    .dvalid(dvalid), .dready(dready), .dwdata(dwdata), .dwvalid(dwvalid),
    .dwready(dwready), .drdata(drdata), .drvalid(drvalid), .ddone(ddone),
    .derr(derr), .mwdata(mwdata), .mmode(mmode), .mvalid(mvalid),
    .mrdata(mrdata), .svalid(svalid), .mbreq(mbreq), .mbgrant(mbgrant),
    .ack(ack), .dbg_state(dbg_state)
  );

  // hdr: bit k is the k-th bit expected on the bus (slave ID, low address, length).
  typedef struct {
    logic        mode;
    logic [15:0] addr;
    logic [3:0]  len;
    logic [31:0] data;
    logic        ack_en;
    int          gnt_dly;
    int          stall_beat;
    int          stall_cyc;
    int          rst_at;
    logic [19:0] hdr;
    logic        exp_err;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic check_reset(input string name);
    check(name, 64'({dready, mvalid, mwdata, mmode, mbreq, drvalid, ddone, derr, dwready, drdata}),
          64'h10000);
  endtask

  function automatic logic [7:0] beat_of(input vec_t v, input int i);
    logic [31:0] t;
    if (i < 4) begin
      t = v.data >> (8 * i);
      return t[7:0];
    end
    return 8'(i * 37 + 5);
  endfunction

  task automatic do_cmd(input int idx, input vec_t v);
    logic        exp_bits[$];
    logic        got_bits[$];
    logic [7:0]  exp_rd[$];
    logic [7:0]  got_rd[$];
    logic [19:0] h;
    logic [7:0]  b;
    int beats, hdr_n, wait_n, i, beat_w, stall_left, dw_cyc, first_bit, done_cyc;
    int sent, rd_cyc, total_rd, n_bad, exp_done, exp_dw;
    bit rd_active, done, aborted, quiet;
    string p;

    p = $sformatf("v%0d", idx);
    beats = int'(v.len) + 1;
    hdr_n = v.ack_en ? 20 : 4;
    for (int k = 0; k < hdr_n; k++) begin
      h = v.hdr >> k;
      exp_bits.push_back(h[0]);
    end
    if (v.ack_en) begin
      for (int bt = 0; bt < beats; bt++) begin
        if (v.mode) begin
          for (int k = 0; k < 8; k++) begin
            b = beat_of(v, bt) >> k;
            exp_bits.push_back(b[0]);
          end
        end else begin
          exp_rd.push_back(beat_of(v, bt));
        end
      end
    end

    daddr = v.addr; dmode = v.mode; dlen = v.len; dvalid = 1'b1;
    ack = v.ack_en; mbgrant = (v.gnt_dly == 0);
    wait_n = 0;
    while (!dready && wait_n < 20) begin
      @(negedge clk);
      wait_n++;
    end
    check({p, "_accept_wait"}, 64'(wait_n), prev_done ? 64'd1 : 64'd0);
    @(posedge clk); #1;
    dvalid = 1'b0; daddr = 16'h0; dlen = 4'h0;

    i = 0; done = 0; aborted = 0; first_bit = -1; done_cyc = -1;
    beat_w = 0; stall_left = v.stall_cyc; dw_cyc = 0;
    sent = 0; rd_cyc = 0; rd_active = 0; total_rd = beats * 8;
    while (!done && !aborted && i < 1000) begin
      i++;
      mbgrant = (i > v.gnt_dly);
      if (beat_w < beats && beat_w == v.stall_beat && stall_left > 0) begin
        dwvalid = 1'b0;
      end else begin
        dwvalid = (beat_w < beats);
        dwdata  = beat_of(v, beat_w);
      end
      if (rd_active && sent < total_rd) begin
        svalid = ((rd_cyc % 3) != 2);
        b = beat_of(v, sent / 8);
        mrdata = b[3'(sent % 8)];
        rd_cyc++;
      end else begin
        svalid = 1'b0;
        mrdata = 1'b0;
      end
      @(negedge clk);
      if (svalid) sent++;
      if (dwready) begin
        dw_cyc++;
        if (dwvalid) beat_w++;
        else stall_left--;
      end
      if (i == 1) begin
        check({p, "_mmode_latched"}, 64'(mmode), 64'(v.mode));
        check({p, "_derr_cleared"}, 64'(derr), 64'd0);
      end
      if (mvalid) begin
        got_bits.push_back(mwdata);
        if (first_bit < 0) first_bit = i;
      end
      if (drvalid) got_rd.push_back(drdata);
      if (!v.mode && !rd_active && got_bits.size() == 20) rd_active = 1'b1;
      if (v.rst_at > 0 && got_bits.size() == v.rst_at) begin
        @(posedge clk); #1;
        rst = 1'b1; dwvalid = 1'b0; svalid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check_reset({p, "_midburst_reset"});
        quiet = 1'b1;
        repeat (3) begin
          @(negedge clk);
          if (ddone || mbreq || mvalid) quiet = 1'b0;
        end
        check({p, "_quiet_after_reset"}, 64'(quiet), 64'd1);
        aborted = 1'b1;
      end else if (ddone) begin
        done = 1'b1;
        done_cyc = i;
        check({p, "_derr"}, 64'(derr), 64'(v.exp_err));
        check({p, "_mbreq_in_done"}, 64'(mbreq), 64'd0);
        check({p, "_mmode_held"}, 64'(mmode), 64'(v.mode));
      end
      if (!done && !aborted) begin
        @(posedge clk); #1;
      end
    end
    dwvalid = 1'b0; svalid = 1'b0; mrdata = 1'b0;
    prev_done = done;

    if (!done && !aborted) begin
      errors++;
      checks++;
      $display("FAIL %s_ddone_timeout actual=none required=ddone within 1000 cycles", p);
    end
    if (done) begin
      check({p, "_first_bit_cycle"}, 64'(first_bit), 64'(3 + v.gnt_dly));
      check({p, "_bit_count"}, 64'(got_bits.size()), 64'(exp_bits.size()));
      n_bad = 0;
      for (int k = 0; k < exp_bits.size() && k < got_bits.size(); k++)
        if (got_bits[k] !== exp_bits[k]) n_bad++;
      check({p, "_bit_errors"}, 64'(n_bad), 64'd0);
      exp_dw = (v.mode && v.ack_en) ? beats + v.stall_cyc : 0;
      check({p, "_dwready_cycles"}, 64'(dw_cyc), 64'(exp_dw));
      check({p, "_rd_beats"}, 64'(got_rd.size()), 64'(exp_rd.size()));
      n_bad = 0;
      for (int k = 0; k < exp_rd.size() && k < got_rd.size(); k++)
        if (got_rd[k] !== exp_rd[k]) n_bad++;
      check({p, "_rd_data_errors"}, 64'(n_bad), 64'd0);
      if (v.mode || !v.ack_en) begin
        exp_done = v.ack_en ? (2 + v.gnt_dly + 4 + 1 + 12 + 4 + beats * 9 + v.stall_cyc)
                            : (2 + v.gnt_dly + 4 + 16);
        check({p, "_done_cycle"}, 64'(done_cyc), 64'(exp_done));
      end
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL global_watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; dvalid = 1'b0; daddr = 16'h0; dmode = 1'b0; dlen = 4'h0;
    dwdata = 8'h0; dwvalid = 1'b0; mrdata = 1'b0; svalid = 1'b0;
    mbgrant = 1'b0; ack = 1'b0;

    //           mode  addr      len   data          ack  gnt stb stc rst  hdr          err
    vecs[0] = '{1'b1, 16'h3A5C, 4'h0, 32'h000000C3, 1'b1, 0, -1, 0,  0, 20'h0A5C3, 1'b0};
    vecs[1] = '{1'b0, 16'h7123, 4'h3, 32'h44332211, 1'b1, 0, -1, 0,  0, 20'h31237, 1'b0};
    vecs[2] = '{1'b1, 16'h1F00, 4'h1, 32'h00005AA5, 1'b1, 2,  1, 5,  0, 20'h1F001, 1'b0};
    vecs[3] = '{1'b1, 16'h9ABC, 4'h2, 32'h00112233, 1'b0, 0, -1, 0,  0, 20'h2ABC9, 1'b1};
    vecs[4] = '{1'b0, 16'h0001, 4'h0, 32'h000000E7, 1'b1, 0, -1, 0,  0, 20'h00010, 1'b0};
    vecs[5] = '{1'b1, 16'hFFFF, 4'hF, 32'h12345678, 1'b1, 0, -1, 0,  0, 20'hFFFFF, 1'b0};
    vecs[6] = '{1'b1, 16'h2468, 4'h1, 32'h00003C96, 1'b1, 0, -1, 0, 32, 20'h14682, 1'b0};
    vecs[7] = '{1'b0, 16'hC0DE, 4'h2, 32'h00A5F00F, 1'b1, 0, -1, 0,  0, 20'h20DEC, 1'b0};

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_reset("reset_outs");

    for (int k = 0; k < 8; k++) do_cmd(k, vecs[k]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/burst_master_port.md
# burst_master_port

Parametrised bit-serial bus master port with burst transfers. It accepts a command (address, mode, burst length) from a master device and requests the serial bus from the arbiter. It then serialises slave ID, memory address and burst length, and transfers 1 to 2^LEN_WIDTH data beats. It sits between a master device and the shared serial bus, arbiter and address decoder. Unlike the single-beat port, it adds a configurable slave-ID width, bursts, per-beat write back-pressure, read-beat delivery and an ack timeout with error reporting.

## Interface
- ADDR_WIDTH, 16, full address width (slave ID + memory address)
- DATA_WIDTH, 8, beat width
- SLAVE_ID_WIDTH, 4, upper address bits identifying the slave; must be < ADDR_WIDTH
- LEN_WIDTH, 4, burst length field width; beats = dlen+1
- ACK_TIMEOUT, 16, max cycles waited for decoder ack (>=1)
- clk  in  1  clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- daddr  in  ADDR_WIDTH  command address
- dmode  in  1  0 read, 1 write
- dlen  in  LEN_WIDTH  beats minus one
- dvalid  in  1  command valid
- dready  out  1  command accepted when dvalid&dready
- dwdata  in  DATA_WIDTH  write beat data
- dwvalid  in  1  write beat valid
- dwready  out  1  port ready for next write beat
- drdata  out  DATA_WIDTH  read beat data
- drvalid  out  1  one-cycle pulse, drdata valid; no back-pressure
- ddone  out  1  one-cycle pulse, command finished
- derr  out  1  error status of last command (ack timeout)
- mwdata  out  1  serial write data/address bit
- mmode  out  1  mode of current command
- mvalid  out  1  mwdata valid
- mrdata  in  1  serial read data bit
- svalid  in  1  mrdata valid
- mbreq  out  1  bus request
- mbgrant  in  1  bus grant
- ack  in  1  address decoder acknowledge

## Operation
- States: IDLE, REQ, SADDR, WAIT, ADDR, LEN, WLOAD, WDATA, RDATA, DONE.
- IDLE: dready=1. On dvalid, latch daddr, dmode, dlen, clear derr, go REQ.
- REQ: mbreq=1; on mbgrant go SADDR. mbgrant is sampled only in REQ.
- SADDR: one bit per cycle of daddr[ADDR_WIDTH-1 -: SLAVE_ID_WIDTH], LSB first. Go WAIT after SLAVE_ID_WIDTH bits.
- WAIT: mvalid=0. Cycle counter runs. If ack is seen, go ADDR. If ACK_TIMEOUT cycles pass without ack, set derr=1 and go DONE (no data phase).
- ADDR: ADDR_WIDTH-SLAVE_ID_WIDTH low address bits, LSB first. Then go to LEN.
- LEN: dlen, LSB first. Then go WLOAD if write, RDATA if read.
- WLOAD: dwready=1, mvalid=0. On dwvalid, capture dwdata and go WDATA.
- WDATA: DATA_WIDTH bits, LSB first. After the last bit, go WLOAD if beats remain, else DONE.
- RDATA: mvalid=0. Each cycle with svalid shifts mrdata into bit[counter], LSB first. Cycles without svalid hold the counter. On the DATA_WIDTH-th bit, update drdata and pulse drvalid the next cycle. Go DONE after the last beat, else stay in RDATA with counter=0.
- DONE: ddone=1 for one cycle, then IDLE.
- mbreq=1 in REQ through the last data state. mbreq=0 in IDLE and DONE.
- mmode = latched mode and is held until the next command.
- Beat counter is LEN_WIDTH+1 bits wide. dlen=all-ones gives 2^LEN_WIDTH beats with no wrap.
- The bit counter is sized to the maximum of the field widths and ACK_TIMEOUT.

## Timing
- Reset: state IDLE; mwdata, mvalid, mmode, mbreq, drvalid, ddone, derr, dwready = 0; drdata = 0; dready=1 the cycle after reset. Reset mid-burst aborts immediately with no ddone.
- mwdata and mvalid are registered. A bit issued in state cycle k appears on the bus in cycle k+1.
- mvalid drops to 0 the cycle after leaving SADDR, ADDR, LEN or WDATA into WAIT, WLOAD or DONE.
- Command acceptance to REQ takes 1 cycle. With mbgrant already high, first SADDR bit is on the bus 3 cycles after the dvalid cycle.
- Write beat cost: 1 WLOAD cycle (if dwvalid is high) + DATA_WIDTH cycles. Each cycle that dwvalid is low adds one stall cycle.
- Ack present on the first WAIT cycle costs 1 cycle. Timeout: ddone with derr=1 after exactly ACK_TIMEOUT WAIT cycles.
- derr is valid with ddone and holds until the next command is accepted.

## Test plan
- Single write: daddr=0x3A5C, dwdata=0xC3, dlen=0, grant and ack immediate. Bus sequence: 1,1,0,0 | 0x A5C LSB first | 0,0,0,0 | 1,1,0,0,0,0,1,1, then ddone=1, derr=0, mbreq=0.
- 4-beat read, dlen=3: slave returns 0x11, 0x22, 0x33, 0x44 with svalid gaps. Expect 4 drvalid pulses in order, then ddone.
- Write stall, dlen=1: dwvalid low for 5 cycles before beat 2. mvalid=0 for those cycles; beat 2 = 0x5A follows intact.
- Ack timeout: ack held low. ddone and derr=1 after 16 WAIT cycles; no ADDR bits sent; mbreq=0 in DONE.
- Reset asserted during WDATA of beat 2: all outputs return to reset values next cycle; a new command completes normally.
- Back-to-back: a read completes, dvalid held high. The next write is accepted in the IDLE cycle after DONE, and derr from a prior timeout is cleared.
